// File: rtl/pulse_sequencer.sv
// Multi-channel pulse scheduler: per-channel WAIT/PULSE/GAP timing, launched together by one start strobe.
// Latency: pulse_out registered, first pulse at the start edge when WAIT=0; done one cycle at the final busy drop.
// No backpressure: config writes to busy channels and starts while any channel runs are dropped.
module pulse_sequencer #(
   parameter int NUM_CH    = 4,
   parameter int CNT_WIDTH = 16,
   parameter int CH_W      = (NUM_CH <= 1) ? 1 : $clog2(NUM_CH)
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [2:0]           cfg_field,
   input  logic [CNT_WIDTH-1:0] cfg_wdata,
   input  logic                 start,
   input  logic                 stop,
   output logic [NUM_CH-1:0]    pulse_out,
   output logic [NUM_CH-1:0]    busy,
   output logic                 done
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PULSE, ST_GAP} state_t;

   typedef struct packed {
      logic [CNT_WIDTH-1:0] wait_cyc;
      logic [CNT_WIDTH-1:0] width;
      logic [CNT_WIDTH-1:0] gap;
      logic [CNT_WIDTH-1:0] count;
      logic                 init;
      logic                 en;
   } ch_cfg_t;

   ch_cfg_t              cfg_q  [NUM_CH];
   state_t               state_q[NUM_CH];
   state_t               state_d[NUM_CH];
   logic [CNT_WIDTH-1:0] cyc_q  [NUM_CH];
   logic [CNT_WIDTH-1:0] cyc_d  [NUM_CH];
   logic [CNT_WIDTH-1:0] pcnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0] pcnt_d [NUM_CH];
   logic [CNT_WIDTH-1:0] eff_w  [NUM_CH];
   logic [NUM_CH-1:0]    busy_int;
   logic [NUM_CH-1:0]    en_vec;
   logic [NUM_CH-1:0]    pulse_d;
   logic                 launch;
   logic                 done_d;
   logic                 cfg_ok;
   logic                 all_idle_d;

   assign busy = busy_int;

   always_comb begin
      busy_int = '0;
      en_vec   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy_int[i] = (state_q[i] != ST_IDLE);
         en_vec[i]   = cfg_q[i].en;
      end
      launch = start && !stop && (busy_int == '0) && (|en_vec);
      cfg_ok = cfg_we && (int'(cfg_ch) < NUM_CH) && !busy_int[cfg_ch];
   end

   // cyc counts cycles spent in the current state, starting at 1 on entry
   always_comb begin
      all_idle_d = 1'b1;
      pulse_d    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cyc_d[i]   = cyc_q[i];
         pcnt_d[i]  = pcnt_q[i];
         eff_w[i]   = (cfg_q[i].width == '0) ? CNT_WIDTH'(1) : cfg_q[i].width;
         case (state_q[i])
            ST_IDLE: begin
               if (launch && cfg_q[i].en) begin
                  pcnt_d[i]  = '0;
                  cyc_d[i]   = CNT_WIDTH'(1);
                  state_d[i] = (cfg_q[i].wait_cyc == '0) ? ST_PULSE : ST_WAIT;
               end
            end
            ST_WAIT, ST_GAP: begin
               if (cyc_q[i] == ((state_q[i] == ST_WAIT) ? cfg_q[i].wait_cyc : cfg_q[i].gap)) begin
                  state_d[i] = ST_PULSE;
                  cyc_d[i]   = CNT_WIDTH'(1);
               end else begin
                  cyc_d[i] = cyc_q[i] + CNT_WIDTH'(1);
               end
            end
            ST_PULSE: begin
               if (cyc_q[i] == eff_w[i]) begin
                  cyc_d[i] = CNT_WIDTH'(1);
                  if ((cfg_q[i].count != '0) && (pcnt_q[i] + CNT_WIDTH'(1) == cfg_q[i].count)) begin
                     state_d[i] = ST_IDLE;
                  end else begin
                     // COUNT=0 runs forever, so its pulse counter is frozen to avoid wrapping
                     if (cfg_q[i].count != '0) pcnt_d[i] = pcnt_q[i] + CNT_WIDTH'(1);
                     state_d[i] = (cfg_q[i].gap == '0) ? ST_PULSE : ST_GAP;
                  end
               end else begin
                  cyc_d[i] = cyc_q[i] + CNT_WIDTH'(1);
               end
            end
            default: state_d[i] = ST_IDLE;
         endcase
         if (stop) state_d[i] = ST_IDLE;
         pulse_d[i] = (state_d[i] == ST_PULSE) ? ~cfg_q[i].init : cfg_q[i].init;
         if (state_d[i] != ST_IDLE) all_idle_d = 1'b0;
      end
      done_d = (|busy_int) && all_idle_d && !stop;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cfg_q[i]   <= '0;
            state_q[i] <= ST_IDLE;
            cyc_q[i]   <= '0;
            pcnt_q[i]  <= '0;
         end
         pulse_out <= '0;
         done      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cyc_q[i]   <= cyc_d[i];
            pcnt_q[i]  <= pcnt_d[i];
         end
         pulse_out <= pulse_d;
         done      <= done_d;
         if (cfg_ok) begin
            case (cfg_field)
               3'd0: cfg_q[cfg_ch].wait_cyc <= cfg_wdata;
               3'd1: cfg_q[cfg_ch].width    <= cfg_wdata;
               3'd2: cfg_q[cfg_ch].gap      <= cfg_wdata;
               3'd3: cfg_q[cfg_ch].count    <= cfg_wdata;
               3'd4: begin
                  cfg_q[cfg_ch].init <= cfg_wdata[0];
                  cfg_q[cfg_ch].en   <= cfg_wdata[1];
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: expected {pulse_out,busy,done} per cycle is derived from the
// closed-form pulse timing, queued at launch and popped as each cycle of DUT output is observed.
module tb_pulse_sequencer;

   localparam int NUM_CH    = 4;
   localparam int CNT_WIDTH = 16;
   localparam int CH_W      = 2;
   localparam int VW        = 2 * NUM_CH + 1;

   logic                 clk_in = 1'b0;
   logic                 rst_n;
   logic                 cfg_we;
   logic [CH_W-1:0]      cfg_ch;
   logic [2:0]           cfg_field;
   logic [CNT_WIDTH-1:0] cfg_wdata;
   logic                 start;
   logic                 stop;
   logic [NUM_CH-1:0]    pulse_out;
   logic [NUM_CH-1:0]    busy;
   logic                 done;

   int checks = 0;
   int errors = 0;

   int tb_wait [NUM_CH];
   int tb_width[NUM_CH];
   int tb_gap  [NUM_CH];
   int tb_count[NUM_CH];
   bit tb_init [NUM_CH];
   bit tb_en   [NUM_CH];

   logic [VW-1:0] exp_q[$];

   pulse_sequencer #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_field(cfg_field),
      .cfg_wdata(cfg_wdata),
      .start    (start),
      .stop     (stop),
      .pulse_out(pulse_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_shadow();
      for (int c = 0; c < NUM_CH; c++) begin
         tb_wait[c] = 0; tb_width[c] = 0; tb_gap[c] = 0; tb_count[c] = 0;
         tb_init[c] = 0; tb_en[c] = 0;
      end
   endtask

   // Called just after a negedge on an idle channel; the write lands on the next posedge.
   task automatic cfg_write(input int ch, input int field, input int data);
      cfg_we    = 1'b1;
      cfg_ch    = ch[CH_W-1:0];
      cfg_field = field[2:0];
      cfg_wdata = data[CNT_WIDTH-1:0];
      @(negedge clk_in);
      cfg_we = 1'b0;
      case (field)
         0: tb_wait[ch]  = data;
         1: tb_width[ch] = data;
         2: tb_gap[ch]   = data;
         3: tb_count[ch] = data;
         4: begin tb_init[ch] = data[0]; tb_en[ch] = data[1]; end
         default: ;
      endcase
   endtask

   task automatic set_ch(input int ch, input int w8, input int wd, input int gp, input int cn, input int ctrl);
      cfg_write(ch, 0, w8);
      cfg_write(ch, 1, wd);
      cfg_write(ch, 2, gp);
      cfg_write(ch, 3, cn);
      cfg_write(ch, 4, ctrl);
   endtask

   // Expected {pulse_out, busy, done} after edge E(n); stop_at<0 means no stop.
   function automatic logic [VW-1:0] exp_vec(input int n, input int stop_at);
      logic [NUM_CH-1:0] p;
      logic [NUM_CH-1:0] b;
      logic d;
      bit launched, fin, stopped;
      int last, w, endp;
      p = '0; b = '0; launched = 0; fin = 1; last = -1;
      for (int c = 0; c < NUM_CH; c++) begin
         p[c] = tb_init[c];
         if (tb_en[c]) launched = 1;
      end
      if (stop_at == 0) launched = 0;
      stopped = (stop_at >= 0) && (n >= stop_at);
      if (launched) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!tb_en[c]) continue;
            w = (tb_width[c] == 0) ? 1 : tb_width[c];
            if (tb_count[c] == 0) begin
               fin = 0;
               endp = 1 << 30;
            end else begin
               endp = tb_wait[c] + tb_count[c] * w + (tb_count[c] - 1) * tb_gap[c];
               if (endp > last) last = endp;
            end
            if (!stopped) begin
               if (n < endp) b[c] = 1'b1;
               for (int k = 0; (tb_count[c] == 0 || k < tb_count[c]) &&
                               (tb_wait[c] + k * (w + tb_gap[c]) <= n); k++) begin
                  if (n < tb_wait[c] + k * (w + tb_gap[c]) + w) p[c] = ~tb_init[c];
               end
            end
         end
      end
      d = launched && fin && (n == last) && !stopped;
      return {p, b, d};
   endfunction

   // Pulses start, then compares ncyc cycles. poke_at>=0 injects a busy-time write + restart.
   task automatic run_launch(input string name, input int ncyc, input int stop_at, input int poke_at);
      for (int n = 0; n < ncyc; n++) exp_q.push_back(exp_vec(n, stop_at));
      start = 1'b1;
      stop  = (stop_at == 0);
      @(negedge clk_in);
      start = 1'b0;
      stop  = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         chk($sformatf("%s n=%0d {pulse,busy,done}", name, n), 32'({pulse_out, busy, done}),
             32'(exp_q.pop_front()));
         stop = (n + 1 == stop_at);
         if (n == poke_at) begin
            cfg_we = 1'b1; cfg_ch = '0; cfg_field = 3'd1; cfg_wdata = 16'd7; start = 1'b1;
         end else begin
            cfg_we = 1'b0; start = 1'b0;
         end
         @(negedge clk_in);
      end
      stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_field = '0; cfg_wdata = '0;
      start = 1'b0; stop = 1'b0;
      clear_shadow();
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);
      chk("reset pulse_out", 32'(pulse_out), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);

      // INIT change on an idle channel shows up one edge after the write edge
      cfg_write(0, 4, 1);
      chk("init lag", 32'(pulse_out[0]), 32'd0);
      @(negedge clk_in);
      chk("init follow", 32'(pulse_out[0]), 32'd1);

      set_ch(0, 2, 3, 1, 2, 2);
      @(negedge clk_in);
      run_launch("basic", 14, -1, -1);
      run_launch("busy_poke", 14, -1, 3);

      set_ch(0, 0, 1, 0, 1, 2);
      set_ch(1, 5, 2, 0, 1, 3);
      @(negedge clk_in);
      run_launch("two_ch", 11, -1, -1);

      set_ch(1, 0, 0, 0, 0, 0);
      set_ch(0, 0, 2, 2, 0, 2);
      @(negedge clk_in);
      run_launch("repeat_stop", 26, 20, -1);
      run_launch("start_stop", 4, 0, -1);
      run_launch("after_stop", 6, 4, -1);

      set_ch(0, 0, 4, 0, 3, 1);
      @(negedge clk_in);
      run_launch("merged_init1", 16, -1, -1);

      // asynchronous reset in the middle of a pulse
      set_ch(0, 2, 3, 1, 2, 2);
      @(negedge clk_in);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      repeat (2) @(negedge clk_in);
      chk("pre_rst pulse", 32'(pulse_out[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst pulse_out", 32'(pulse_out), 32'd0);
      chk("async_rst busy", 32'(busy), 32'd0);
      chk("async_rst done", 32'(done), 32'd0);
      @(negedge clk_in);
      rst_n = 1'b1;
      clear_shadow();
      @(negedge clk_in);
      run_launch("post_rst", 6, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
